// File: rtl/touch_spi_responder_pkg.sv
// Shared definitions for touch_spi_responder: APB register offsets, FSM states
// and the channel codes carried in command bits [6:4].
package touch_spi_responder_pkg;

  localparam logic [4:0] OFS_CTRL     = 5'h00;
  localparam logic [4:0] OFS_XDATA    = 5'h04;
  localparam logic [4:0] OFS_YDATA    = 5'h08;
  localparam logic [4:0] OFS_STATUS   = 5'h0C;
  localparam logic [4:0] OFS_LAST_CMD = 5'h10;

  localparam logic [2:0] CH_X = 3'b101;
  localparam logic [2:0] CH_Y = 3'b001;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_DATA   = 2'd2,
    ST_IGNORE = 2'd3
  } state_e;

endpackage

// File: rtl/touch_spi_responder_edge_sync.sv
// spi_edge_sync: STAGES-deep synchronizer (STAGES >= 2) for one SPI input,
// plus rise/fall pulses of the synchronized level. All flops clear to 0.
module spi_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/touch_spi_responder.sv
// touch_spi_responder: APB-programmed responder for an ADS7843-style SPI touch link.
// Define TOUCH_SPI_RESP_CMDLOG_EN to add the LAST_CMD / abort-count register at 0x10.
module touch_spi_responder
  import touch_spi_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESULT_W    = 12
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        SPI_SCLK,
  input  logic        SPI_SS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        PENIRQ_N
);

  logic sclk_rise_s, sclk_fall_s, sclk_lvl_unused_s;
  logic ss_lvl_s, ss_rise_s, ss_fall_unused_s;
  logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;
  logic ss_fall_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(PCLK), .rst_n(PRESERN), .din(SPI_SCLK),
    .level(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(PCLK), .rst_n(PRESERN), .din(SPI_SS),
    .level(ss_lvl_s), .rise(ss_rise_s), .fall(ss_fall_unused_s));
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(PCLK), .rst_n(PRESERN), .din(SPI_MOSI),
    .level(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s));
  assign ss_fall_s = ss_fall_unused_s;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          cmd_q, cmd_d, next_cmd_s;
  logic [RESULT_W-1:0] shadow_q, shadow_d, chan_val_s;
  logic [WORD_W-1:0]   word_s;
  logic                miso_q, miso_d;
  logic                enable_q, enable_d, pen_down_q, pen_down_d, irq_q, irq_d;
  logic [RESULT_W-1:0] xdata_q, xdata_d, ydata_q, ydata_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                frame_set_s, abort_s, cmd_done_s;
  logic                wr_s, sel_ctrl_s, sel_x_s, sel_y_s, sel_stat_s, sel_log_s, mapped_s;
  logic                apb_unused_s;

  assign apb_unused_s = ^{PADDR[31:5], PADDR[1:0], PWDATA};
  assign next_cmd_s   = {cmd_q[6:0], mosi_s};
  assign word_s       = WORD_W'(shadow_q) << (WORD_W - RESULT_W);

  always_comb begin
    case (next_cmd_s[6:4])
      CH_X:    chan_val_s = xdata_q;
      CH_Y:    chan_val_s = ydata_q;
      default: chan_val_s = '0;
    endcase
  end

  // Frame sequencing; an SS rise outside IDLE always wins over SCLK activity.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    shadow_d    = shadow_q;
    frame_set_s = 1'b0;
    abort_s     = 1'b0;
    cmd_done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s && enable_q) begin
          state_d   = ST_CMD;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
        end else if (sclk_rise_s) begin
          cmd_d     = next_cmd_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            cmd_done_s = 1'b1;
            bit_cnt_d  = 4'd0;
            if (next_cmd_s[7]) begin
              state_d  = ST_DATA;
              shadow_d = chan_val_s;
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            state_d = ST_CMD;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
        end else if (sclk_fall_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_d     = ST_IDLE;
            frame_set_s = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_IGNORE: begin
        if (ss_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IGNORE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (state_q == ST_DATA && !ss_lvl_s) begin
      if (sclk_fall_s) begin
        miso_d = word_s[4'd15 - bit_cnt_q];
      end else begin
        miso_d = miso_q;
      end
    end else begin
      miso_d = 1'b0;
    end
  end

  assign wr_s = PSEL & PENABLE & PWRITE;

  always_comb begin
    sel_ctrl_s = 1'b0;
    sel_x_s    = 1'b0;
    sel_y_s    = 1'b0;
    sel_stat_s = 1'b0;
    sel_log_s  = 1'b0;
    case (PADDR[4:2])
      OFS_CTRL[4:2]:     sel_ctrl_s = 1'b1;
      OFS_XDATA[4:2]:    sel_x_s    = 1'b1;
      OFS_YDATA[4:2]:    sel_y_s    = 1'b1;
      OFS_STATUS[4:2]:   sel_stat_s = 1'b1;
`ifdef TOUCH_SPI_RESP_CMDLOG_EN
      OFS_LAST_CMD[4:2]: sel_log_s  = 1'b1;
`endif
      default:           sel_log_s  = 1'b0;
    endcase
    mapped_s = sel_ctrl_s | sel_x_s | sel_y_s | sel_stat_s | sel_log_s;
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped_s;

  // Register file updates; a frame completion beats a same-cycle W1C.
  always_comb begin
    enable_d   = enable_q;
    pen_down_d = pen_down_q;
    xdata_d    = xdata_q;
    ydata_d    = ydata_q;
    if (wr_s && sel_ctrl_s) begin
      enable_d   = PWDATA[0];
      pen_down_d = PWDATA[1];
    end else if (wr_s && sel_x_s) begin
      xdata_d = PWDATA[RESULT_W-1:0];
    end else if (wr_s && sel_y_s) begin
      ydata_d = PWDATA[RESULT_W-1:0];
    end else begin
      enable_d = enable_q;
    end
    if (frame_set_s) begin
      frame_done_d = 1'b1;
    end else if (wr_s && sel_stat_s && PWDATA[1]) begin
      frame_done_d = 1'b0;
    end else begin
      frame_done_d = frame_done_q;
    end
    frame_cnt_d = frame_cnt_q + {7'd0, frame_set_s};
    irq_d       = pen_down_q & enable_q;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      cmd_q        <= 8'd0;
      shadow_q     <= '0;
      miso_q       <= 1'b0;
      enable_q     <= 1'b0;
      pen_down_q   <= 1'b0;
      irq_q        <= 1'b0;
      xdata_q      <= '0;
      ydata_q      <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      cmd_q        <= cmd_d;
      shadow_q     <= shadow_d;
      miso_q       <= miso_d;
      enable_q     <= enable_d;
      pen_down_q   <= pen_down_d;
      irq_q        <= irq_d;
      xdata_q      <= xdata_d;
      ydata_q      <= ydata_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

`ifdef TOUCH_SPI_RESP_CMDLOG_EN
  logic [7:0] last_cmd_q, last_cmd_d, abort_cnt_q, abort_cnt_d;

  always_comb begin
    if (cmd_done_s) begin
      last_cmd_d = next_cmd_s;
    end else begin
      last_cmd_d = last_cmd_q;
    end
    if (abort_s && abort_cnt_q != 8'hFF) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end else begin
      abort_cnt_d = abort_cnt_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      last_cmd_q  <= 8'd0;
      abort_cnt_q <= 8'd0;
    end else begin
      last_cmd_q  <= last_cmd_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end
`else
  logic log_unused_s;
  assign log_unused_s = cmd_done_s ^ abort_s;
`endif

  always_comb begin
    if (!PSEL) begin
      PRDATA = 32'd0;
    end else if (sel_ctrl_s) begin
      PRDATA = {30'd0, pen_down_q, enable_q};
    end else if (sel_x_s) begin
      PRDATA = 32'(xdata_q);
    end else if (sel_y_s) begin
      PRDATA = 32'(ydata_q);
    end else if (sel_stat_s) begin
      PRDATA = {16'd0, frame_cnt_q, 6'd0, frame_done_q, (state_q != ST_IDLE)};
`ifdef TOUCH_SPI_RESP_CMDLOG_EN
    end else if (sel_log_s) begin
      PRDATA = {16'd0, abort_cnt_q, last_cmd_q};
`endif
    end else begin
      PRDATA = 32'd0;
    end
  end

  assign SPI_MISO = miso_q;
  assign PENIRQ_N = ~irq_q;

endmodule
